// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   NUM_REQ     : number of requesters (fixed at four)
//   arb_state_t : FSM state encoding shared by RTL and anything that
//                 needs to decode it (IDLE=0, GRANT=1, GAP=2)
package rr_arbiter_4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority winner select, purely combinational.
//   req     : request lines, bit i = requester i
//   ptr     : index holding top priority this round
//   win_idx : first requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   win_vld : at least one request is present
module rr_pick_4
    import rr_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         win_idx,
    output logic               win_vld
);

    logic [1:0] cand;

    // Scan from the lowest priority upwards so the highest-priority hit
    // is the last one written and therefore wins.
    always_comb begin
        win_idx = ptr;
        win_vld = 1'b0;
        cand    = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold timer.
// {gnt_en, gnt_idx} drives the enable/select of a 2-to-4 decoder directly.
//   clk     : rising-edge clock
//   rst     : asynchronous, active-high reset
//   req     : level-sensitive request lines, bit i = requester i
//   done    : single-cycle release pulse from the current owner
//   gnt_idx : current owner; only meaningful while gnt_en=1
//   gnt_en  : grant active
//   timeout : one-cycle pulse when the hold timer forces a release
//   busy    : FSM is outside IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; arbitrate among pending requests
// GRANT | owner fixed, hold counter running
// GAP   | one dead cycle so grants to successive owners never overlap
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [1:0]         gnt_idx,
    output logic               gnt_en,
    output logic               timeout,
    output logic               busy
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t  state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [1:0]  gnt_idx_nxt;
    logic        gnt_en_nxt, timeout_nxt, busy_nxt;
    logic [1:0]  win_idx;
    logic        win_vld;
    logic        rel_done, rel_drop, rel_hold;

    rr_pick_4 u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign rel_done = done;
    assign rel_drop = ~req[gnt_idx];
    // cnt counts cycles already held beyond the first, so MAX_HOLD-1 here
    // means the owner is in its MAX_HOLD-th cycle.
    assign rel_hold = (cnt == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        gnt_idx_nxt = gnt_idx;
        gnt_en_nxt  = gnt_en;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_en_nxt = 1'b0;
                if (win_vld) begin
                    state_nxt   = GRANT;
                    gnt_idx_nxt = win_idx;
                    gnt_en_nxt  = 1'b1;
                    ptr_nxt     = win_idx + 2'd1;
                    cnt_nxt     = '0;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_hold) begin
                    state_nxt   = GAP;
                    gnt_en_nxt  = 1'b0;
                    // A voluntary release in the same cycle is not a timeout.
                    timeout_nxt = rel_hold & ~rel_done & ~rel_drop;
                end else if (cnt != HOLD_W'(MAX_HOLD)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                state_nxt  = IDLE;
                gnt_en_nxt = 1'b0;
            end
            default: begin
                state_nxt  = IDLE;
                gnt_en_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'b00;
            cnt     <= '0;
            gnt_idx <= 2'b00;
            gnt_en  <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            gnt_en  <= gnt_en_nxt;
            timeout <= timeout_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule
